spi_flash_fetch: RTL



---
 rtl/uc_flash_pkg.sv | 18 +
 rtl/spi_bit_engine.sv | 104 ++++++++++
 rtl/spi_flash_fetch.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/uc_flash_pkg.sv
`default_nettype none
// uc_flash_pkg: shared constants and state encoding for the SPI flash instruction fetch.
package uc_flash_pkg;
  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam int         CMD_BITS  = 8;
  localparam int         ADDR_BITS = 24;
  localparam int         DATA_BITS = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    ADDR = 3'd2,
    DATA = 3'd3,
    HOLD = 3'd4,
    GAP  = 3'd5
  } state_e;
endpackage
`default_nettype wire

// File: rtl/spi_bit_engine.sv
`default_nettype none
// spi_bit_engine: mode-0 SPI shifter with SCK divider; sends MSB-first from tx, samples MISO into rx.
module spi_bit_engine #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        start_i,
  input  logic        early_i,
  input  logic [4:0]  nbits_i,
  input  logic [23:0] tx_i,
  input  logic        abort_i,
  input  logic        miso_i,
  output logic        sck_o,
  output logic        mosi_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] rx_o
);
  localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic          busy_q, busy_d;
  logic          sck_q, sck_d;
  logic [DW-1:0] div_q, div_d;
  logic [4:0]    bits_q, bits_d;
  logic [23:0]   tx_q, tx_d;
  logic [15:0]   rx_q, rx_d;
  logic          phase_end;

  assign phase_end = busy_q && (div_q == DIV_LAST);

  always_comb begin
    busy_d = busy_q;
    sck_d  = sck_q;
    div_d  = div_q;
    bits_d = bits_q;
    tx_d   = tx_q;
    rx_d   = rx_q;
    if (start_i) begin
      busy_d = 1'b1;
      sck_d  = 1'b0;
      div_d  = '0;
      bits_d = nbits_i - 5'd1;
      tx_d   = tx_i;
      // Early start: SCK has already been low during the start cycle, so it counts as low time.
      if (early_i) begin
        if (CLK_DIV == 1) begin
          sck_d = 1'b1;
          rx_d  = {rx_q[14:0], miso_i};
        end else begin
          div_d = DW'(1);
        end
      end
    end else if (busy_q) begin
      if (abort_i && !sck_q) begin
        busy_d = 1'b0;
        tx_d   = '0;
        div_d  = '0;
      end else if (phase_end) begin
        div_d = '0;
        sck_d = ~sck_q;
        if (!sck_q) begin
          rx_d = {rx_q[14:0], miso_i};
        end else begin
          tx_d = {tx_q[22:0], 1'b0};
          if (bits_q == 5'd0 || abort_i) begin
            busy_d = 1'b0;
            tx_d   = '0;
          end else begin
            bits_d = bits_q - 5'd1;
          end
        end
      end else begin
        div_d = div_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      busy_q <= 1'b0;
      sck_q  <= 1'b0;
      div_q  <= '0;
      bits_q <= '0;
      tx_q   <= '0;
      rx_q   <= '0;
    end else begin
      busy_q <= busy_d;
      sck_q  <= sck_d;
      div_q  <= div_d;
      bits_q <= bits_d;
      tx_q   <= tx_d;
      rx_q   <= rx_d;
    end
  end

  assign sck_o  = sck_q;
  assign mosi_o = tx_q[23];
  assign busy_o = busy_q;
  assign done_o = phase_end && sck_q && (bits_q == 5'd0);
  assign rx_o   = rx_q;
endmodule
`default_nettype wire

// File: rtl/spi_flash_fetch.sv
`default_nettype none
// spi_flash_fetch: fetches 16-bit instruction words from SPI NOR flash, streaming sequential PCs.
module spi_flash_fetch
  import uc_flash_pkg::*;
#(
  parameter int          ADDR_WIDTH = 12,
  parameter int          CLK_DIV    = 2,
  parameter logic [23:0] BASE_ADDR  = 24'h000000,
  parameter int          CS_HIGH    = 4
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  output logic [15:0]           flash_data,
  output logic                  flash_ready,
  output logic                  spi_sck,
  output logic                  spi_cs_n,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);
  localparam int            GW       = (CS_HIGH > 1) ? $clog2(CS_HIGH) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(CS_HIGH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] req_q, req_d, tag_q, tag_d;
  logic                  valid_q, valid_d, cs_n_q, cs_n_d;
  logic [15:0]           data_q, data_d;
  logic [GW-1:0]         gap_q, gap_d;

  logic        eng_start, eng_early, eng_abort, eng_busy, eng_done;
  logic [4:0]  eng_nbits;
  logic [23:0] eng_tx, byte_addr;
  logic [15:0] eng_rx;
  logic        miss, req_chg, seq_next;

  assign byte_addr = BASE_ADDR + 24'({req_q, 1'b0});
  assign miss      = !valid_q || (tag_q != pc_in);
  assign req_chg   = (pc_in != req_q);
  assign seq_next  = (tag_q != '1) && (pc_in == tag_q + ADDR_WIDTH'(1));

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    tag_d     = tag_q;
    valid_d   = valid_q;
    data_d    = data_q;
    cs_n_d    = cs_n_q;
    gap_d     = gap_q;
    eng_start = 1'b0;
    eng_early = 1'b0;
    eng_abort = 1'b0;
    eng_nbits = '0;
    eng_tx    = '0;
    case (state_q)
      IDLE: if (miss) begin
        req_d     = pc_in;
        cs_n_d    = 1'b0;
        eng_start = 1'b1;
        eng_nbits = 5'(CMD_BITS);
        eng_tx    = {CMD_READ, 16'h0000};
        state_d   = CMD;
      end
      CMD, ADDR, DATA: begin
        eng_abort = req_chg;
        // The engine only goes idle here once an abort has let SCK settle low.
        if (!eng_busy) begin
          cs_n_d  = 1'b1;
          gap_d   = GAP_LOAD;
          state_d = GAP;
        end else if (!req_chg && eng_done) begin
          if (state_q == CMD) begin
            eng_start = 1'b1;
            eng_nbits = 5'(ADDR_BITS);
            eng_tx    = byte_addr;
            state_d   = ADDR;
          end else if (state_q == ADDR) begin
            eng_start = 1'b1;
            eng_nbits = 5'(DATA_BITS);
            state_d   = DATA;
          end else begin
            data_d  = eng_rx;
            tag_d   = req_q;
            valid_d = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: if (pc_in != tag_q) begin
        if (seq_next) begin
          req_d     = pc_in;
          eng_start = 1'b1;
          eng_early = 1'b1;
          eng_nbits = 5'(DATA_BITS);
          state_d   = DATA;
        end else begin
          cs_n_d  = 1'b1;
          gap_d   = GAP_LOAD;
          state_d = GAP;
        end
      end
      GAP: if (gap_q == '0) state_d = IDLE; else gap_d = gap_q - GW'(1);
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= 16'h0000;
      cs_n_q  <= 1'b1;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      tag_q   <= tag_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      cs_n_q  <= cs_n_d;
      gap_q   <= gap_d;
    end
  end

  spi_bit_engine #(.CLK_DIV(CLK_DIV)) u_engine (
    .clk     (clk),
    .arst_n  (arst_n),
    .start_i (eng_start),
    .early_i (eng_early),
    .nbits_i (eng_nbits),
    .tx_i    (eng_tx),
    .abort_i (eng_abort),
    .miso_i  (spi_miso),
    .sck_o   (spi_sck),
    .mosi_o  (spi_mosi),
    .busy_o  (eng_busy),
    .done_o  (eng_done),
    .rx_o    (eng_rx)
  );

  assign flash_data  = data_q;
  assign flash_ready = valid_q && (tag_q == pc_in);
  assign spi_cs_n    = cs_n_q;
endmodule
`default_nettype wire
